// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, FSM state type and result flags.
package alu_pkg;

    localparam int unsigned OPW = 4;

    typedef logic [OPW-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'd0;
    localparam opcode_t OP_ADD = 4'd1;
    localparam opcode_t OP_SUB = 4'd2;
    localparam opcode_t OP_AND = 4'd3;
    localparam opcode_t OP_NOT = 4'd4;
    localparam opcode_t OP_OR  = 4'd5;
    localparam opcode_t OP_XOR = 4'd6;
    localparam opcode_t OP_SHL = 4'd7;
    localparam opcode_t OP_SHR = 4'd8;
    localparam opcode_t OP_MUL = 4'd9;

    typedef enum logic [0:0] {
        StIdle,
        StMult
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
        logic ovf;
        logic ill;
    } flags_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
// done_o marks the final iteration; product_o carries that iteration's sum the same cycle.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_step;

    always_comb begin
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));
        product_o = acc_step;
    end

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready handshakes on both sides and registered result/flags.
// Define ALU_PIPE_MUL_EN to add the multi-cycle MUL opcode; otherwise opcode 9 is illegal.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             neg,
    output logic             ovf,
    output logic             ill
);

    logic               accept;
    logic               out_free;
    logic               is_mul;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    flags_t             flags_q, flags_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] shl_w;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic               res_ill;

    function automatic flags_t make_flags(logic [WIDTH-1:0] r, logic c, logic v, logic i);
        flags_t f;
        f.zero  = (r == '0);
        f.carry = c;
        f.neg   = r[WIDTH-1];
        f.ovf   = v;
        f.ill   = i;
        return f;
    endfunction

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; MUL is produced by the sequential multiplier instead.
    always_comb begin
        shamt   = alu_in2[SHW-1:0];
        sum_w   = {1'b0, alu_in1} + {1'b0, alu_in2};
        diff_w  = {1'b0, alu_in1} - {1'b0, alu_in2};
        shl_w   = {{WIDTH{1'b0}}, alu_in1} << shamt;
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        case (opcode)
            OP_NOP: res = '0;
            OP_ADD: begin
                res   = sum_w[WIDTH-1:0];
                res_c = sum_w[WIDTH];
                res_v = (alu_in1[WIDTH-1] == alu_in2[WIDTH-1]) &&
                        (sum_w[WIDTH-1] != alu_in1[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff_w[WIDTH-1:0];
                res_c = diff_w[WIDTH];
                res_v = (alu_in1[WIDTH-1] != alu_in2[WIDTH-1]) &&
                        (diff_w[WIDTH-1] != alu_in1[WIDTH-1]);
            end
            OP_AND: res = alu_in1 & alu_in2;
            OP_NOT: res = ~alu_in1;
            OP_OR:  res = alu_in1 | alu_in2;
            OP_XOR: res = alu_in1 ^ alu_in2;
            OP_SHL: begin
                res   = shl_w[WIDTH-1:0];
                res_c = shl_w[WIDTH];
            end
            OP_SHR: res = alu_in1 >> shamt;
            default: res_ill = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    state_e             state_q, state_d;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign is_mul    = (opcode == OP_MUL);
    assign mul_start = accept && is_mul;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (mul_start) state_d = StMult;
            StMult: if (mul_done)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state_q == StIdle) && out_free;
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (mul_start),
        .a_i      (alu_in1),
        .b_i      (alu_in2),
        .done_o   (mul_done),
        .product_o(mul_prod)
    );
`else
    assign is_mul = 1'b0;

    always_comb begin
        in_ready = rst_n && out_free;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
        flags_d     = flags_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && !is_mul) begin
            out_valid_d = 1'b1;
            alu_out_d   = res;
            flags_d     = make_flags(res, res_c, res_v, res_ill);
        end
`ifdef ALU_PIPE_MUL_EN
        // Output register is guaranteed free here: MUL was only accepted with it draining.
        if (mul_done) begin
            out_valid_d = 1'b1;
            alu_out_d   = mul_prod[WIDTH-1:0];
            flags_d     = make_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH],
                                     1'b0, 1'b0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign neg       = flags_q.neg;
    assign ovf       = flags_q.ovf;
    assign ill       = flags_q.ill;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; legal range 2..32.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/opcode present.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 opcode  input  4  operation select.
REQ-008 alu_in1, alu_in2  input  WIDTH  operands.
REQ-009 out_valid  output  1  result registers hold an unconsumed result.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 alu_out  output  WIDTH  result.
REQ-012 zero, carry, neg, ovf, ill  output  1 each  result flags.

Function
REQ-013 Accept on in_valid & in_ready; deliver on out_valid & out_ready.
REQ-014 Opcodes: NOP=0 (result 0), ADD=1, SUB=2, AND=3, NOT=4 (~alu_in1), OR=5, XOR=6, SHL=7, SHR=8 (logical), MUL=9; all arithmetic modulo 2^WIDTH.
REQ-015 Shifts use alu_in2[SHW-1:0] as amount; upper alu_in2 bits ignored.
REQ-016 Opcodes 10..15: alu_out=0, ill=1, other flags per REQ-017; ill=0 for every legal opcode.
REQ-017 zero = (alu_out==0); neg = alu_out[WIDTH-1]; carry = ADD carry-out, SUB borrow (in1<in2 unsigned), SHL last bit shifted out (0 for amount 0), MUL any nonzero bit of upper WIDTH product bits, else 0; ovf = signed overflow for ADD/SUB, else 0.
REQ-018 FSM states IDLE, MULT. IDLE: in_ready = !out_valid | out_ready.
REQ-019 Non-MUL op accepted in IDLE: result and flags registered at the next edge, out_valid=1 (latency 1 cycle); back-to-back throughput 1 op/cycle while out_ready=1.
REQ-020 MUL accepted in IDLE: capture operands, enter MULT; shift-add one multiplier bit per cycle for WIDTH cycles; in_ready=0 throughout MULT.
REQ-021 MULT exit: low WIDTH product bits load alu_out with out_valid=1 exactly WIDTH+1 cycles after acceptance; return to IDLE.
REQ-022 MULT completion while a prior result is still unconsumed: not possible; MUL acceptance requires output register free after this cycle (REQ-018).
REQ-023 Result, flags, out_valid held stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous deliver and accept in IDLE: new result replaces old in same edge, out_valid stays 1.
REQ-025 Input signals ignored when in_ready=0 or in_valid=0.

Reset
REQ-026 rst_n=0 forces immediately: state=IDLE, out_valid=0, alu_out=0, all flags 0, multiplier registers 0; in_ready=0 while rst_n=0, 1 in first cycle after release.
REQ-027 Reset during MULT aborts the multiply; no result is produced after release.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN: defined -> MUL and MULT state implemented as above; undefined -> no MULT state or multiplier logic, opcode 9 treated as illegal per REQ-016 with latency 1.

Structure
REQ-029 Shared package alu_pkg holds opcode constants (NOP..MUL), the FSM state typedef, and opcode width 4.
REQ-030 Sub-module alu_mul_seq holds the iterative shift-add multiplier (start, done, operands, 2*WIDTH product), instantiated only under ALU_PIPE_MUL_EN.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-031 ADD 0xFF,0x01 -> next cycle alu_out=0x00, zero=1, carry=1, ovf=0, neg=0.
REQ-032 SUB 0x80,0x01 -> alu_out=0x7F, ovf=1, carry=0; SUB 0x01,0x02 -> 0xFF, carry=1, neg=1.
REQ-033 SHL 0x81 by 0x09 (amount 1) -> 0x02, carry=1; opcode 12 -> alu_out=0, ill=1, zero=1.
REQ-034 Backpressure: out_ready=0, ADD 3,4 accepted then in_ready=0; alu_out=0x07 held 5 cycles; out_ready=1 with simultaneous new AND 0xF0,0x3C -> next cycle 0x30.
REQ-035 With ALU_PIPE_MUL_EN: MUL 0x10,0x11 -> out_valid 9 cycles after acceptance, alu_out=0x10, carry=1, in_ready=0 during MULT; without macro: next cycle alu_out=0, ill=1.
REQ-036 rst_n pulse low 4 cycles into MUL -> out_valid=0 immediately, no result after release, ADD 1,1 then returns 0x02 next cycle.
